sha3_absorb_feeder: RTL and testbench

Upstream stage of the SHA3-512 Keccak core in the ROLLO-II encrypt datapath. Reads the message (the packed error vector E) word by word from the E memory, packs it into RATE-bit blocks, applies SHA-3 pad10*1 with the domain suffix, and hands each block to the permutation core over a valid/ready handshake. It replaces the core's direct memory access, so the core only absorbs ready-made rate blocks.

---
 rtl/sha3_absorb_feeder_pkg.sv | 30 +++
 rtl/sha3_absorb_feeder_pad.sv | 30 +++
 rtl/sha3_absorb_feeder.sv | 168 ++++++++++++++++
 tb/tb_sha3_absorb_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_absorb_feeder_pkg.sv
// Shared definitions for the SHA3 absorb feeder: FSM encoding, padding bytes
// and block geometry helpers.
package sha3_absorb_feeder_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_OFFER = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_LAST     = 8'h80;

  // Word slots per rate block.
  function automatic int calc_w(input int rate, input int digit);
    return rate / digit;
  endfunction

  // Block count; a message that exactly fills its last block gets a pad-only block.
  function automatic int calc_nb(input int msg_bits, input int rate);
    return (msg_bits / rate) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha3_absorb_feeder_pad.sv
// Combinational pad10*1 stage: XORs the domain byte and the closing 0x80 into
// a final block. SHA3_FEEDER_SHAKE_EN selects the SHAKE domain byte.
module sha3_pad_unit
  import sha3_absorb_feeder_pkg::*;
#(
  parameter int RATE  = 576,
  parameter int OFF_W = 7
) (
  input  logic [RATE-1:0]  blk_i,
  input  logic [OFF_W-1:0] byte_off_i,
  input  logic             last_i,
  output logic [RATE-1:0]  blk_o
);

`ifdef SHA3_FEEDER_SHAKE_EN
  localparam logic [7:0] DOMAIN = DOMAIN_SHAKE;
`else
  localparam logic [7:0] DOMAIN = DOMAIN_SHA3;
`endif

  // Sequential XORs so a shared last byte naturally becomes DOMAIN ^ 0x80.
  always_comb begin
    blk_o = blk_i;
    if (last_i) begin
      blk_o[32'(byte_off_i) * 8 +: 8] = blk_o[32'(byte_off_i) * 8 +: 8] ^ DOMAIN;
      blk_o[RATE-8 +: 8]              = blk_o[RATE-8 +: 8] ^ PAD_LAST;
    end
  end

endmodule

// File: rtl/sha3_absorb_feeder.sv
// Reads the message from the E memory, packs it into padded rate blocks and
// offers them to the Keccak core. SHA3_FEEDER_SHAKE_EN selects SHAKE padding.
module sha3_absorb_feeder
  import sha3_absorb_feeder_pkg::*;
#(
  parameter int MSG_BITS = 1152,
  parameter int DIGIT    = 32,
  parameter int RATE     = 576,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DIGIT-1:0]  mem_dout,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [RATE-1:0]   blk_data,
  output logic              blk_last,
  output logic [2:0]        dbg_state
);

  // Handshake: a block transfers in any cycle where blk_valid && blk_ready;
  // blk_data/blk_last are held until then and blk_valid never drops early.

  localparam int W      = calc_w(RATE, DIGIT);
  localparam int NB     = calc_nb(MSG_BITS, RATE);
  localparam int SLOT_W = idx_w(W);
  localparam int BLK_W  = idx_w(NB);
  localparam int OFF_W  = idx_w(RATE / 8);
  localparam logic [OFF_W-1:0] BYTE_OFF = OFF_W'((MSG_BITS / 8) % (RATE / 8));

  logic [2:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [RATE-1:0]   block_q, block_d;
  logic              pend_q, pend_d;
  logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
  logic [DIGIT-1:0]  pend_mask_q, pend_mask_d;

  logic [31:0]       word_idx;
  logic [31:0]       word_base;
  logic              slot_has_msg;
  logic [DIGIT-1:0]  word_mask;
  logic              is_final;
  logic              in_fetch;
  logic [RATE-1:0]   merged;
  logic [RATE-1:0]   padded;

  // Global word position of the current slot and how much of it is message.
  always_comb begin
    word_idx     = 32'(blk_q) * 32'(W) + 32'(slot_q);
    word_base    = word_idx * 32'(DIGIT);
    slot_has_msg = word_base < 32'(MSG_BITS);
    for (int b = 0; b < DIGIT; b++) begin
      word_mask[b] = (word_base + 32'(b)) < 32'(MSG_BITS);
    end
  end

  assign is_final  = (blk_q == BLK_W'(NB - 1));
  assign in_fetch  = (state_q == ST_FETCH);
  assign mem_rd_en = in_fetch && slot_has_msg;
  assign mem_addr  = mem_rd_en ? word_idx[ADDR_W-1:0] : '0;

  // Read data arrives one cycle after the strobe; fold it in as it lands.
  always_comb begin
    merged = block_q;
    if (pend_q) begin
      merged[32'(pend_slot_q) * DIGIT +: DIGIT] = mem_dout & pend_mask_q;
    end
  end

  sha3_pad_unit #(
    .RATE  (RATE),
    .OFF_W (OFF_W)
  ) u_pad (
    .blk_i      (merged),
    .byte_off_i (BYTE_OFF),
    .last_i     (is_final),
    .blk_o      (padded)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    blk_d       = blk_q;
    block_d     = block_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    pend_mask_d = pend_mask_q;
    case (state_q)
      ST_IDLE: begin
        block_d = '0;
        if (start) begin
          slot_d  = '0;
          blk_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        block_d     = merged;
        pend_d      = mem_rd_en;
        pend_slot_d = slot_q;
        pend_mask_d = word_mask;
        if (slot_q == SLOT_W'(W - 1)) begin
          state_d = ST_PAD;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_PAD: begin
        block_d = padded;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (blk_ready) begin
          if (is_final) begin
            state_d = ST_FIN;
          end else begin
            blk_d   = blk_q + 1'b1;
            slot_d  = '0;
            block_d = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        block_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      blk_q       <= '0;
      block_q     <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      pend_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      blk_q       <= blk_d;
      block_q     <= block_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      pend_mask_q <= pend_mask_d;
    end
  end

  // All outputs decode from registers only, so blk_ready never reaches them.
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_PAD) || (state_q == ST_OFFER);
  assign done      = (state_q == ST_FIN);
  assign blk_valid = (state_q == ST_OFFER);
  assign blk_last  = blk_valid && is_final;
  assign blk_data  = block_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha3_absorb_feeder.sv
// Directed bench for sha3_absorb_feeder: four instances with message lengths
// 0, 568, 576 and 1152 bits share one clock and reset.
module tb_sha3_absorb_feeder;

  localparam int DIGIT  = 32;
  localparam int RATE   = 576;
  localparam int ADDR_W = 10;
  localparam int NI     = 4;

`ifdef SHA3_FEEDER_SHAKE_EN
  localparam logic [7:0] DOM = 8'h1F;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif

  logic              clk = 1'b0;
  logic              rst_b;
  logic              start     [NI];
  logic              blk_ready [NI];
  logic              busy      [NI];
  logic              done      [NI];
  logic              mem_rd_en [NI];
  logic              blk_valid [NI];
  logic              blk_last  [NI];
  logic [ADDR_W-1:0] mem_addr  [NI];
  logic [RATE-1:0]   blk_data  [NI];
  logic [2:0]        dbg_state [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // E memory contents: instance 1 holds its word index, the others a scrambled pattern.
  function automatic logic [31:0] wordval(input int g, input int a);
    if (g == 1) return 32'(a);
    return (32'(a) * 32'h01000193) ^ 32'hA5A55A5A;
  endfunction

  // Reference block built byte by byte from the memory image, then padded.
  function automatic logic [RATE-1:0] exp_block(input int mb, input int g, input int b);
    logic [RATE-1:0] r;
    logic [31:0]     w;
    int              pos;
    int              nb;
    r  = '0;
    nb = mb / RATE + 1;
    for (int i = 0; i < RATE / 8; i++) begin
      pos = b * RATE + i * 8;
      if (pos < mb) begin
        w = wordval(g, pos / DIGIT);
        r[i*8 +: 8] = w[(pos % DIGIT) +: 8];
      end
    end
    if (b == nb - 1) begin
      r[((mb / 8) % (RATE / 8)) * 8 +: 8] = r[((mb / 8) % (RATE / 8)) * 8 +: 8] ^ DOM;
      r[RATE-8 +: 8] = r[RATE-8 +: 8] ^ 8'h80;
    end
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MB = (g == 0) ? 0 : (g == 1) ? 568 : (g == 2) ? 576 : 1152;
    logic [DIGIT-1:0]  mem_dout;
    logic [ADDR_W-1:0] rd_log [64];
    int rd_cnt   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    sha3_absorb_feeder #(
      .MSG_BITS (MB),
      .DIGIT    (DIGIT),
      .RATE     (RATE),
      .ADDR_W   (ADDR_W)
    ) u_dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .mem_rd_en (mem_rd_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_dout  (mem_dout),
      .blk_valid (blk_valid[g]),
      .blk_ready (blk_ready[g]),
      .blk_data  (blk_data[g]),
      .blk_last  (blk_last[g]),
      .dbg_state (dbg_state[g])
    );

    always @(posedge clk) begin
      if (mem_rd_en[g]) begin
        mem_dout <= wordval(g, int'(mem_addr[g]));
        if (rd_cnt < 64) rd_log[rd_cnt] <= mem_addr[g];
        rd_cnt <= rd_cnt + 1;
      end
      if (blk_valid[g] && blk_ready[g]) hs_cnt <= hs_cnt + 1;
      if (done[g]) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int g);
    chk("rst_busy", busy[g], 0);
    chk("rst_done", done[g], 0);
    chk("rst_rd_en", mem_rd_en[g], 0);
    chk("rst_addr", mem_addr[g], 0);
    chk("rst_valid", blk_valid[g], 0);
    chk("rst_last", blk_last[g], 0);
    chk("rst_data", blk_data[g], 0);
    chk("rst_state", dbg_state[g], 0);
  endtask

  // Called at a falling edge (cycle 0); returns at the falling edge of cycle 1.
  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, input int maxc, output int n);
    n = 0;
    while (!blk_valid[g] && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RATE-1:0] padonly;
    int n, rd0, hs0, dn0;
    logic seen;

    rst_b = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g]     = 1'b0;
      blk_ready[g] = 1'b1;
    end
    blk_ready[3] = 1'b0;
    padonly = '0;
    padonly[7:0] = DOM;
    padonly[RATE-1 -: 8] = 8'h80;

    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk_reset(g);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Empty message: pad-only single block, no reads.
    pulse_start(0);
    chk("a_busy_c1", busy[0], 1);
    repeat (18) @(negedge clk);
    chk("a_valid_c19", blk_valid[0], 0);
    @(negedge clk);
    chk("a_valid_c20", blk_valid[0], 1);
    chk("a_last", blk_last[0], 1);
    chk("a_byte0", blk_data[0][7:0], DOM);
    chk("a_byte71", blk_data[0][RATE-1 -: 8], 8'h80);
    chk("a_data", blk_data[0], padonly);
    @(negedge clk);
    chk("a_done_c21", done[0], 1);
    chk("a_busy_c21", busy[0], 0);
    @(negedge clk);
    chk("a_done_c22", done[0], 0);
    chk("a_reads", g_dut[0].rd_cnt, 0);

    // 568 bits: 18 reads, top byte of word 17 masked and shared pad byte.
    pulse_start(1);
    repeat (19) @(negedge clk);
    chk("b_valid_c20", blk_valid[1], 1);
    chk("b_last", blk_last[1], 1);
    chk("b_word5", blk_data[1][5*32 +: 32], 32'h00000005);
    chk("b_word17", blk_data[1][17*32 +: 32], 32'h86000011);
    chk("b_data", blk_data[1], exp_block(568, 1, 0));
    @(negedge clk);
    chk("b_done", done[1], 1);
    chk("b_reads", g_dut[1].rd_cnt, 18);
    for (int i = 0; i < 18; i++) chk("b_addr", g_dut[1].rd_log[i], i);

    // 576 bits: full raw block then a pad-only block with no reads.
    pulse_start(2);
    repeat (19) @(negedge clk);
    chk("c_valid1", blk_valid[2], 1);
    chk("c_last1", blk_last[2], 0);
    chk("c_data1", blk_data[2], exp_block(576, 2, 0));
    @(negedge clk);
    chk("c_valid_gap", blk_valid[2], 0);
    repeat (19) @(negedge clk);
    chk("c_valid2_c40", blk_valid[2], 1);
    chk("c_last2", blk_last[2], 1);
    chk("c_data2", blk_data[2], padonly);
    @(negedge clk);
    chk("c_done", done[2], 1);
    chk("c_reads", g_dut[2].rd_cnt, 18);

    // 1152 bits with a five-cycle stall on every block.
    rd0 = g_dut[3].rd_cnt;
    hs0 = g_dut[3].hs_cnt;
    dn0 = g_dut[3].done_cnt;
    pulse_start(3);
    for (int b = 0; b < 3; b++) begin
      wait_valid(3, 60, n);
      chk("d_valid_timeout", blk_valid[3], 1);
      for (int s = 0; s < 5; s++) begin
        chk("d_stall_valid", blk_valid[3], 1);
        chk("d_stall_data", blk_data[3], exp_block(1152, 3, b));
        chk("d_stall_last", blk_last[3], (b == 2) ? 1 : 0);
        @(negedge clk);
      end
      blk_ready[3] = 1'b1;
      @(negedge clk);
      blk_ready[3] = 1'b0;
    end
    chk("d_done", done[3], 1);
    repeat (3) @(negedge clk);
    chk("d_hs", g_dut[3].hs_cnt - hs0, 3);
    chk("d_reads", g_dut[3].rd_cnt - rd0, 36);
    chk("d_done_cnt", g_dut[3].done_cnt - dn0, 1);

    // Reset in the middle of FETCH, then a clean rerun.
    blk_ready[3] = 1'b1;
    pulse_start(3);
    repeat (9) @(negedge clk);
    chk("e_busy_c10", busy[3], 1);
    rst_b = 1'b0;
    #1;
    chk_reset(3);
    @(negedge clk);
    chk_reset(3);
    rst_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen = seen | blk_valid[3];
    end
    chk("e_no_partial", seen, 0);
    pulse_start(3);
    wait_valid(3, 60, n);
    chk("e_latency", n, 19);
    chk("e_data", blk_data[3], exp_block(1152, 3, 0));
    chk("e_last", blk_last[3], 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done[3];
    end
    chk("e_done", seen, 1);

    // Second start while busy must not retrigger.
    dn0 = g_dut[0].done_cnt;
    pulse_start(0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("f_valid_c20", blk_valid[0], 1);
    chk("f_byte0", blk_data[0][7:0], DOM);
    repeat (30) @(negedge clk);
    chk("f_done_cnt", g_dut[0].done_cnt - dn0, 1);
    chk("f_busy", busy[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
